// File: rtl/top_test_pairing_uart.sv
// Board-level bring-up top: a TX-pin trigger launches a W-bit Fibonacci
// recurrence (pairing-engine stand-in); the 2W-bit result {B, A} is read
// back one bit per cycle on the RX pin, selected by addr.
module top_test_pairing_uart #(
    parameter int unsigned N_ITER = 300,
    parameter int unsigned W      = 256
) (
    input  logic       default_sysclk1_300_clk_p,
    input  logic       default_sysclk1_300_clk_n,
    input  logic       rstn,
    input  logic       USB_UART_TX,
    input  logic [8:0] addr,
    output logic       USB_UART_RX
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(N_ITER - 1);

    // Differential input receiver model: output follows the positive leg
    // while the pair is complementary.
    logic clk;
    assign clk = default_sysclk1_300_clk_p & ~default_sysclk1_300_clk_n;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            s1_q, s2_q, s3_q;
    logic            rx_q;
    logic            start;
    logic            last_step;
    logic            load;
    logic            step;
    logic [2*W-1:0]  result;

    // Two-flop synchronizer plus edge register for the asynchronous trigger.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= USB_UART_TX;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign start     = s2_q & ~s3_q;
    assign last_step = (cnt_q == LAST_CNT);

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start)     state_d = RUN;
            RUN:        if (last_step) state_d = DONE;
            default:                   state_d = IDLE;
        endcase
    end

    // FSM outputs: load on a start outside RUN, step every RUN cycle.
    always_comb begin
        load = 1'b0;
        step = 1'b0;
        case (state_q)
            IDLE, DONE: load = start;
            RUN:        step = 1'b1;
            default:    ;
        endcase
    end

    // Datapath next state: initialise to F(0)/F(1), then advance one term.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        if (load) begin
            a_d   = '0;
            b_d   = {{(W-1){1'b0}}, 1'b1};
            cnt_d = '0;
        end else if (step) begin
            a_d   = b_q;
            b_d   = a_q + b_q;
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Operand and iteration counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

    assign result = {b_q, a_q};

    // Registered single-bit readout of the result, every cycle in every state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_q <= 1'b0;
        end else begin
            rx_q <= result[addr];
        end
    end

    assign USB_UART_RX = rx_q;

endmodule

// File: tb/tb_top_test_pairing_uart.sv
// Bench for top_test_pairing_uart: two instances (N_ITER=10 and 300) share
// stimulus; a cycle-level Fibonacci model predicts RX every cycle, and
// directed reads are checked against literals and a fast-doubling reference.
module tb_top_test_pairing_uart;

    logic       clk_p = 1'b0;
    logic       clk_n;
    logic       rstn  = 1'b0;
    logic       tx    = 1'b0;
    logic [8:0] addr  = '0;
    logic       rx10, rx300;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    always #5 clk_p = ~clk_p;
    assign clk_n = ~clk_p;

    top_test_pairing_uart #(.N_ITER(10), .W(256)) dut10 (
        .default_sysclk1_300_clk_p(clk_p),
        .default_sysclk1_300_clk_n(clk_n),
        .rstn(rstn),
        .USB_UART_TX(tx),
        .addr(addr),
        .USB_UART_RX(rx10)
    );

    top_test_pairing_uart #(.N_ITER(300), .W(256)) dut300 (
        .default_sysclk1_300_clk_p(clk_p),
        .default_sysclk1_300_clk_n(clk_n),
        .rstn(rstn),
        .USB_UART_TX(tx),
        .addr(addr),
        .USB_UART_RX(rx300)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference {F(n+1), F(n)} by fast doubling, independent of step-by-step iteration.
    function automatic logic [511:0] fib_pair(input int unsigned n);
        logic [511:0] a, b, c, d;
        a = '0;
        b = 512'd1;
        for (int i = 15; i >= 0; i--) begin
            c = a * ((b << 1) - a);
            d = a * a + b * b;
            if (n[i]) begin
                a = d;
                b = c + d;
            end else begin
                a = c;
                b = d;
            end
        end
        return {b[255:0], a[255:0]};
    endfunction

    // Behavioural model: TX sampled each edge; a 0->1 step in the samples
    // starts a run two edges later unless one is in progress; a run is N
    // Fibonacci steps from (0,1).
    bit             smp [3];
    logic [255:0]   ma  [2];
    logic [255:0]   mb  [2];
    int unsigned    mk  [2];
    bit             mrun[2];
    int unsigned    n_it[2];

    initial begin
        logic [511:0] r;
        logic         exp_rx [2];
        logic         start_now;
        n_it[0] = 10;
        n_it[1] = 300;
        for (int i = 0; i < 2; i++) begin
            ma[i] = '0; mb[i] = '0; mk[i] = 0; mrun[i] = 0;
        end
        for (int i = 0; i < 3; i++) smp[i] = 0;
        forever begin
            @(posedge clk_p);
            for (int i = 0; i < 2; i++) begin
                r = {mb[i], ma[i]};
                exp_rx[i] = rstn ? r[addr] : 1'b0;
            end
            if (!rstn) begin
                for (int i = 0; i < 2; i++) begin
                    ma[i] = '0; mb[i] = '0; mk[i] = 0; mrun[i] = 0;
                end
                for (int i = 0; i < 3; i++) smp[i] = 0;
            end else begin
                start_now = smp[1] & ~smp[2];
                for (int i = 0; i < 2; i++) begin
                    if (mrun[i]) begin
                        {ma[i], mb[i]} = {mb[i], ma[i] + mb[i]};
                        mk[i]++;
                        if (mk[i] == n_it[i]) mrun[i] = 0;
                    end else if (start_now) begin
                        ma[i] = '0; mb[i] = 256'd1; mk[i] = 0; mrun[i] = 1;
                    end
                end
                smp[2] = smp[1];
                smp[1] = smp[0];
                smp[0] = tx;
            end
            #1;
            check("rx_n10_cycle",  {255'd0, rx10},  {255'd0, exp_rx[0]});
            check("rx_n300_cycle", {255'd0, rx300}, {255'd0, exp_rx[1]});
        end
    end

    task automatic pulse();
        @(negedge clk_p) tx = 1'b1;
        @(negedge clk_p) tx = 1'b0;
    endtask

    // Idle cycles with addr walking the low bits of A and B so in-flight values are compared.
    task automatic wait_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk_p);
            addr = 9'(((i % 2) != 0 ? 256 : 0) + (i / 2) % 8);
        end
    endtask

    task automatic read_bit(input logic [8:0] a, output logic b10, output logic b300);
        @(negedge clk_p) addr = a;
        @(posedge clk_p);
        #1;
        b10  = rx10;
        b300 = rx300;
    endtask

    task automatic sweep(output logic [511:0] r10, output logic [511:0] r300);
        logic b10, b300;
        for (int unsigned a = 0; a < 512; a++) begin
            read_bit(9'(a), b10, b300);
            r10[a]  = b10;
            r300[a] = b300;
        end
    endtask

    initial begin
        logic [511:0] r10, r300, ref300;
        logic         b10, b300;
        ref300 = fib_pair(300);

        // 1. reset, release, no trigger: all bits read 0
        #1000;
        @(negedge clk_p) rstn = 1'b1;
        sweep(r10, r300);
        check("idle_n10_A",  r10[255:0],    256'd0);
        check("idle_n10_B",  r10[511:256],  256'd0);
        check("idle_n300_A", r300[255:0],   256'd0);
        check("idle_n300_B", r300[511:256], 256'd0);

        // 2. N_ITER=10 run: A=55, B=89
        pulse();
        wait_cycles(16);
        sweep(r10, r300);
        check("n10_A", r10[255:0],   256'd55);
        check("n10_B", r10[511:256], 256'd89);
        read_bit(9'd0,   b10, b300); check("n10_bit0",   {255'd0, b10}, 256'd1);
        read_bit(9'd1,   b10, b300); check("n10_bit1",   {255'd0, b10}, 256'd1);
        read_bit(9'd2,   b10, b300); check("n10_bit2",   {255'd0, b10}, 256'd1);
        read_bit(9'd3,   b10, b300); check("n10_bit3",   {255'd0, b10}, 256'd0);
        read_bit(9'd4,   b10, b300); check("n10_bit4",   {255'd0, b10}, 256'd1);
        read_bit(9'd5,   b10, b300); check("n10_bit5",   {255'd0, b10}, 256'd1);
        read_bit(9'd256, b10, b300); check("n10_bit256", {255'd0, b10}, 256'd1);
        read_bit(9'd259, b10, b300); check("n10_bit259", {255'd0, b10}, 256'd1);
        read_bit(9'd262, b10, b300); check("n10_bit262", {255'd0, b10}, 256'd1);
        read_bit(9'hF0,  b10, b300); check("n10_bitF0",  {255'd0, b10}, 256'd0);

        // 3. N_ITER=300 run against the fast-doubling reference
        pulse();
        wait_cycles(1000);
        sweep(r10, r300);
        check("n300_A", r300[255:0],   ref300[255:0]);
        check("n300_B", r300[511:256], ref300[511:256]);
        check("n300_A_lsb", {255'd0, r300[0]}, 256'd0);
        read_bit(9'hF0, b10, b300); check("n300_bitF0", {255'd0, b300}, 256'd0);
        check("n10_rerun_A", r10[255:0],   256'd55);
        check("n10_rerun_B", r10[511:256], 256'd89);

        // 4. second trigger during a run is ignored
        pulse();
        wait_cycles(5);
        pulse();
        wait_cycles(20);
        sweep(r10, r300);
        check("mid_trig_A", r10[255:0],   256'd55);
        check("mid_trig_B", r10[511:256], 256'd89);

        // 5. reset mid-run aborts to zero; a new trigger redoes the run
        wait_cycles(1000);
        pulse();
        wait_cycles(6);
        @(negedge clk_p) rstn = 1'b0;
        wait_cycles(3);
        @(negedge clk_p) rstn = 1'b1;
        sweep(r10, r300);
        check("abort_A", r10[255:0],   256'd0);
        check("abort_B", r10[511:256], 256'd0);
        check("abort_n300", r300, 512'd0);
        pulse();
        wait_cycles(20);
        sweep(r10, r300);
        check("after_abort_A", r10[255:0],   256'd55);
        check("after_abort_B", r10[511:256], 256'd89);

        // 6. addr walk after DONE, then a back-to-back run reproduces the result
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_p) addr = (i == 1) ? 9'hF0 : 9'd0;
            repeat (10) @(negedge clk_p);
        end
        read_bit(9'd0,  b10, b300); check("walk_bit0",  {255'd0, b10}, 256'd1);
        read_bit(9'hF0, b10, b300); check("walk_bitF0", {255'd0, b10}, 256'd0);
        wait_cycles(1000);
        pulse();
        wait_cycles(1000);
        sweep(r10, r300);
        check("b2b_n10_A",  r10[255:0],    256'd55);
        check("b2b_n10_B",  r10[511:256],  256'd89);
        check("b2b_n300_A", r300[255:0],   ref300[255:0]);
        check("b2b_n300_B", r300[511:256], ref300[511:256]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
